// File: rtl/push_debounce_pulse.sv
// Two-channel push-button conditioner: synchronize, debounce and turn each accepted press into a one-cycle pulse.
// Optional auto-repeat while a button stays pressed is enabled by defining PUSH_AUTO_REPEAT_EN.
module push_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter bit PUSH_ACTIVE_LOW = 1'b0,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [1:0] i_Push_Raw,
  output logic [1:0] o_Push,
  output logic [1:0] o_Held
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]       IDLE_LVL = PUSH_ACTIVE_LOW ? 2'b11 : 2'b00;

  // Reject parameter sets the counters cannot represent at elaboration time.
  if ((DEBOUNCE_CYCLES < 2) || (DEBOUNCE_CYCLES > (2 ** CNT_W) - 1) ||
      (REPEAT_DELAY < 1) || (REPEAT_PERIOD < 1)) begin : g_bad_params
    $error("push_debounce_pulse: illegal parameter combination");
  end

`ifdef PUSH_AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
`endif

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [1:0] sync_a;
  logic [1:0] sync_b;
  logic [1:0] sync;
  logic [1:0] press_evt;
  logic [1:0] held_nxt;

  // Two-flop synchronizer; flops idle at the released pin level so reset looks like "not pressed".
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      sync_a <= IDLE_LVL;
      sync_b <= IDLE_LVL;
    end else begin
      sync_a <= i_Push_Raw;
      sync_b <= sync_a;
    end
  end

  assign sync = PUSH_ACTIVE_LOW ? ~sync_b : sync_b;

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             deb_evt;
    logic             rpt_evt;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        state <= RELEASED;
        cnt   <= '0;
      end else begin
        state <= state_nxt;
        cnt   <= cnt_nxt;
      end
    end

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    // A wait state falls back as soon as the level disagrees, so any glitch restarts qualification.
    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      deb_evt   = 1'b0;
      unique case (state)
        RELEASED: begin
          if (sync[ch]) begin
            state_nxt = PRESS_WAIT;
            cnt_nxt   = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync[ch]) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
            deb_evt   = 1'b1;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        PRESSED: begin
          if (!sync[ch]) begin
            state_nxt = RELEASE_WAIT;
            cnt_nxt   = '0;
          end
        end
        RELEASE_WAIT: begin
          if (sync[ch]) begin
            state_nxt = PRESSED;
            cnt_nxt   = '0;
          end else if (cnt == DB_LAST) begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
        default: begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      endcase
    end

`ifdef PUSH_AUTO_REPEAT_EN
    logic [RPT_W-1:0] rpt_cnt;
    logic [RPT_W-1:0] rpt_cnt_nxt;
    logic [RPT_W-1:0] rpt_last;
    logic             rpt_first;
    logic             rpt_first_nxt;

    assign rpt_last = rpt_first ? RPT_DELAY_LAST : RPT_PERIOD_LAST;

    // Repeat timing only advances while the channel stays in PRESSED; any other path rearms the first delay.
    always_comb begin
      rpt_cnt_nxt   = '0;
      rpt_first_nxt = 1'b1;
      rpt_evt       = 1'b0;
      if ((state == PRESSED) && (state_nxt == PRESSED)) begin
        if (rpt_cnt == rpt_last) begin
          rpt_evt       = 1'b1;
          rpt_first_nxt = 1'b0;
        end else begin
          rpt_cnt_nxt   = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + 1'b1;
          rpt_first_nxt = rpt_first;
        end
      end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
      if (!i_Rst) begin
        rpt_cnt   <= '0;
        rpt_first <= 1'b1;
      end else begin
        rpt_cnt   <= rpt_cnt_nxt;
        rpt_first <= rpt_first_nxt;
      end
    end
`else
    assign rpt_evt = 1'b0;
`endif

    assign press_evt[ch] = deb_evt | rpt_evt;
    assign held_nxt[ch]  = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

  // Simultaneous events on both channels are dropped so the counter never sees up and down together.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      o_Push <= 2'b00;
      o_Held <= 2'b00;
    end else begin
      o_Push <= (press_evt == 2'b11) ? 2'b00 : press_evt;
      o_Held <= held_nxt;
    end
  end

endmodule
